datapath_ctrl_fsm: RTL and testbench



---
 rtl/ctrl_pkg.sv | 30 +++
 rtl/ctrl_decode.sv | 25 ++
 rtl/datapath_ctrl_fsm.sv | 99 +++++++++
 tb/tb_datapath_ctrl_fsm.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared states, opcodes, ALU encodings and decode struct for datapath_ctrl_fsm
package ctrl_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_SUBI = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b1000;
  localparam logic [3:0] OP_STR  = 4'b1001;
  localparam logic [3:0] OP_B    = 4'b1100;
  localparam logic [3:0] OP_BEQ  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;
  typedef struct packed {
    logic       is_alu;
    logic       uses_imm;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_cond;
    logic       is_halt;
    logic       is_illegal;
    logic [1:0] alu_op;
  } dec_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode-to-instruction-class decode
// Ports: op (opcode in), d (class flags and ALU operation out)
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] op,
  output dec_t           d
);
  always_comb begin
    d            = '0;
    d.is_alu     = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_SUBI};
    d.uses_imm   = op inside {OP_ADDI, OP_SUBI, OP_LDR, OP_STR, OP_B, OP_BEQ};
    d.is_load    = op == OP_LDR;
    d.is_store   = op == OP_STR;
    d.is_branch  = op inside {OP_B, OP_BEQ};
    d.is_cond    = op == OP_BEQ;
    d.is_halt    = op == OP_HALT;
    d.is_illegal = !(d.is_alu || d.is_load || d.is_store || d.is_branch || d.is_halt);
    d.alu_op     = op inside {OP_SUB, OP_SUBI} ? ALU_SUB :
                   op == OP_AND ? ALU_AND :
                   op == OP_OR  ? ALU_OR  : ALU_ADD;
  end
endmodule

// File: rtl/datapath_ctrl_fsm.sv
// datapath_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit for the 24-bit datapath
// Inputs: clk, rst (async, active-high), inst_op, cero, mem_ready, resume
// Outputs: datapath selects/enables, mem_req/memWrite, halted, illegal and bus_err pulses
// Optional macro CTRL_PERF_COUNTERS_EN adds saturating retired/stall_cyc counters
module datapath_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OPW        = 4,
  parameter int MEM_TO_CYC = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] inst_op,
  input  logic           cero,
  input  logic           mem_ready,
  input  logic           resume,
  output logic           ir_en,
  output logic           pc_en,
  output logic           PCSrc,
  output logic           regWrite,
  output logic           aluSrc,
  output logic           immSrc,
  output logic           ra2Src,
  output logic           memToReg,
  output logic           memWrite,
  output logic           mem_req,
  output logic [1:0]     aluControl,
  output logic           halted,
  output logic           illegal,
  output logic           bus_err
`ifdef CTRL_PERF_COUNTERS_EN
  ,
  output logic [15:0]    retired,
  output logic [15:0]    stall_cyc
`endif
);
  localparam int CW = $clog2(MEM_TO_CYC);
  state_t         state, nxt;
  logic [OPW-1:0] op_q;
  logic [CW-1:0]  cnt;
  dec_t           dec;
  logic           ex, me, wb, mem_to, take;
  // DECODE acts on the live opcode before it is latched; later states use the latched copy
  ctrl_decode #(.OPW(OPW)) u_dec (.op(state == DECODE ? inst_op : op_q), .d(dec));
  assign ex     = state == EXEC;
  assign me     = state == MEM;
  assign wb     = state == WB;
  assign mem_to = me && !mem_ready && cnt == CW'(MEM_TO_CYC - 1);
  assign take   = ex && dec.is_branch && (!dec.is_cond || cero);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FETCH;
      op_q  <= '0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == DECODE) op_q <= inst_op;
      cnt <= (me && !mem_ready && !mem_to) ? cnt + 1'b1 : '0;
    end
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:   nxt = DECODE;
      DECODE:  nxt = dec.is_illegal ? FETCH : dec.is_halt ? HALT : EXEC;
      EXEC:    nxt = dec.is_alu ? WB : (dec.is_load || dec.is_store) ? MEM : FETCH;
      MEM:     nxt = mem_ready ? (dec.is_load ? WB : FETCH) : mem_to ? FETCH : MEM;
      WB:      nxt = FETCH;
      HALT:    nxt = resume ? FETCH : HALT;
      default: nxt = FETCH;
    endcase
  end
  // Outputs are forced low while rst is high so mem_req drops asynchronously
  assign ir_en      = !rst && state == FETCH;
  assign pc_en      = !rst && (state == FETCH || take);
  assign PCSrc      = !rst && take;
  assign regWrite   = !rst && wb;
  assign aluSrc     = !rst && (ex || me || wb) && dec.uses_imm;
  assign immSrc     = !rst && (ex || me || wb) && dec.uses_imm;
  assign ra2Src     = !rst && (ex || me) && dec.is_store;
  assign memToReg   = !rst && wb && dec.is_load;
  assign memWrite   = !rst && me && dec.is_store;
  assign mem_req    = !rst && me;
  assign aluControl = (!rst && (ex || wb)) ? dec.alu_op : ALU_ADD;
  assign halted     = !rst && state == HALT;
  assign illegal    = !rst && state == DECODE && dec.is_illegal;
  assign bus_err    = !rst && mem_to;
`ifdef CTRL_PERF_COUNTERS_EN
  logic ret;
  assign ret = wb || (ex && dec.is_branch) || (me && mem_ready && dec.is_store);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      retired   <= '0;
      stall_cyc <= '0;
    end else begin
      if (ret && retired != 16'hFFFF) retired <= retired + 1'b1;
      if (me && !mem_ready && stall_cyc != 16'hFFFF) stall_cyc <= stall_cyc + 1'b1;
    end
`endif
endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
// tb_datapath_ctrl_fsm: directed plus randomized instruction traces checked against a cycle-trace model
module tb_datapath_ctrl_fsm;
  localparam int IR = 15, PC = 14, PCS = 13, RW = 12, AS = 11, IS = 10, R2 = 9, M2R = 8, MW = 7, MR = 6, H = 3, IL = 2, BE = 1;
  logic clk = 0, rst = 1, cero = 0, mem_ready = 0, resume = 0;
  logic [3:0] inst_op = 0;
  logic ir_en, pc_en, PCSrc, regWrite, aluSrc, immSrc, ra2Src, memToReg, memWrite, mem_req, halted, illegal, bus_err;
  logic [1:0] aluControl;
  logic [15:0] ov;
  int tests = 0, fails = 0, exp_ret = 0, exp_stall = 0;
`ifdef CTRL_PERF_COUNTERS_EN
  logic [15:0] retired, stall_cyc;
`endif
  datapath_ctrl_fsm dut (
    .clk(clk), .rst(rst), .inst_op(inst_op), .cero(cero), .mem_ready(mem_ready), .resume(resume),
    .ir_en(ir_en), .pc_en(pc_en), .PCSrc(PCSrc), .regWrite(regWrite), .aluSrc(aluSrc), .immSrc(immSrc),
    .ra2Src(ra2Src), .memToReg(memToReg), .memWrite(memWrite), .mem_req(mem_req), .aluControl(aluControl),
    .halted(halted), .illegal(illegal), .bus_err(bus_err)
`ifdef CTRL_PERF_COUNTERS_EN
    , .retired(retired), .stall_cyc(stall_cyc)
`endif
  );
  always #5 clk = ~clk;
  assign ov = {ir_en, pc_en, PCSrc, regWrite, aluSrc, immSrc, ra2Src, memToReg, memWrite, mem_req, aluControl, halted, illegal, bus_err, 1'b0};
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic chk_perf(input string tag);
`ifdef CTRL_PERF_COUNTERS_EN
    chk({tag, " retired"}, retired, 16'(exp_ret));
    chk({tag, " stall_cyc"}, stall_cyc, 16'(exp_stall));
`endif
  endtask
  // Builds the expected per-cycle output trace of one instruction from the opcode map,
  // then drives it cycle by cycle: opcode valid only in DECODE, cero only in EXEC,
  // mem_ready rising d cycles into MEM (d >= 15 never), random noise elsewhere.
  task automatic run_instr(input string name, input logic [3:0] op, input bit c, input int d);
    logic [15:0] q[$];
    logic [15:0] e, m;
    bit alu = op <= 4'd5, ldr = op == 4'd8, str = op == 4'd9, br = op == 4'd12 || op == 4'd13;
    bit bad = !(alu || ldr || str || br || op == 4'd15);
    bit imm = op inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd12, 4'd13};
    bit tmo = d >= 15;
    int n = tmo ? 15 : d + 1;
    logic [1:0] ac = (op == 4'd1 || op == 4'd5) ? 2'b01 : op == 4'd2 ? 2'b10 : op == 4'd3 ? 2'b11 : 2'b00;
    q.push_back(16'(1 << IR) | 16'(1 << PC));
    q.push_back(bad ? 16'(1 << IL) : 16'h0);
    if (!bad) begin
      e = {10'b0, ac, 4'b0};
      if (imm) e |= 16'(1 << AS) | 16'(1 << IS);
      if (str) e |= 16'(1 << R2);
      if (br && (op == 4'd12 || c)) e |= 16'(1 << PC) | 16'(1 << PCS);
      q.push_back(e);
      if (alu) q.push_back(e | 16'(1 << RW));
      if (alu || br) exp_ret++;
      if (ldr || str) begin
        m = 16'(1 << MR) | 16'(1 << AS) | 16'(1 << IS);
        if (str) m |= 16'(1 << MW) | 16'(1 << R2);
        for (int k = 0; k < n; k++) q.push_back((tmo && k == n - 1) ? (m | 16'(1 << BE)) : m);
        exp_stall += n - (tmo ? 0 : 1);
        if (!tmo) exp_ret++;
        if (ldr && !tmo) q.push_back(e | 16'(1 << RW) | 16'(1 << M2R));
      end
    end
    for (int i = 0; i < q.size(); i++) begin
      inst_op   = (i == 1) ? op : 4'($urandom);
      cero      = (i == 2) ? c : 1'($urandom);
      mem_ready = ((ldr || str) && i >= 3) ? (i == 3 + d) : 1'($urandom);
      resume    = 1'($urandom);
      #2;
      chk($sformatf("%s[%0d]", name, i), ov, q[i]);
      @(posedge clk);
      #1;
    end
    chk_perf(name);
  endtask
  task automatic run_halt(input int n);
    for (int i = 0; i < n + 3; i++) begin
      inst_op   = (i == 1) ? 4'hF : 4'($urandom);
      resume    = (i < 2) ? 1'($urandom) : (i == n + 2);
      mem_ready = 1'($urandom);
      cero      = 1'($urandom);
      #2;
      chk($sformatf("halt[%0d]", i), ov, i == 0 ? (16'(1 << IR) | 16'(1 << PC)) : i == 1 ? 16'h0 : 16'(1 << H));
      @(posedge clk);
      #1;
    end
    resume = 0;
    chk_perf("halt");
  endtask
  initial begin
    #2;
    chk("reset_outputs", ov, 16'h0);
    @(posedge clk);
    #1;
    chk("reset_held", ov, 16'h0);
    rst = 0;
    chk_perf("reset");
    run_instr("add", 4'd0, 0, 0);
    run_instr("beq_nt", 4'd13, 0, 0);
    run_instr("beq_t", 4'd13, 1, 0);
    run_instr("b", 4'd12, 0, 0);
    run_instr("subi", 4'd5, 0, 0);
    run_instr("or", 4'd3, 0, 0);
    run_instr("ldr_d3", 4'd8, 0, 3);
    run_instr("str_to", 4'd9, 0, 99);
    run_instr("ldr_d14", 4'd8, 0, 14);
    run_instr("ldr_to", 4'd8, 0, 15);
    run_instr("str_d0", 4'd9, 0, 0);
    run_instr("ill6", 4'd6, 0, 0);
    run_halt(10);
    run_instr("and", 4'd2, 1, 0);
    for (int r = 0; r < 40; r++) begin
      logic [3:0] op = 4'($urandom_range(0, 15));
      if (op == 4'hF) run_halt($urandom_range(0, 4));
      else run_instr($sformatf("rnd%0d", r), op, 1'($urandom), $urandom_range(0, 16));
    end
    inst_op = 4'd8;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 0;
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    #1;
    chk("mid_mem_req", ov, 16'(1 << MR) | 16'(1 << AS) | 16'(1 << IS));
    rst = 1;
    #1;
    chk("async_rst_drop", ov, 16'h0);
    @(posedge clk);
    #1;
    chk("rst_hold", ov, 16'h0);
    rst = 0;
    exp_ret = 0;
    exp_stall = 0;
    chk_perf("after_rst");
    run_instr("post_rst_add", 4'd0, 0, 0);
    #2;
    chk("final_fetch", ov, 16'(1 << IR) | 16'(1 << PC));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
